// File: rtl/ndn_interface_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : ndn_interface_endpoint
// Purpose  : Outgoing-interface end of the NDN serial packet link. Receives
//            start-bit framed meta/prefix/data packets on mosi and transmits
//            packets of the same framing on miso. Full duplex, one clock.
// Revision : 1.0 - initial release
// ============================================================================
module ndn_interface_endpoint #(
  parameter int META_W   = 8,
  parameter int PREFIX_W = 64,
  parameter int DATA_W   = 256
) (
  input  logic                clk,
  input  logic                rst,        // asynchronous, active low
  input  logic                mosi,
  input  logic                cs,
  output logic                miso,
  output logic                rx_valid,
  output logic                rx_abort,
  output logic [META_W-1:0]   rx_meta,
  output logic [PREFIX_W-1:0] rx_prefix,
  output logic [DATA_W-1:0]   rx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [META_W-1:0]   tx_meta,
  input  logic [PREFIX_W-1:0] tx_prefix,
  input  logic [DATA_W-1:0]   tx_data,
  output logic                tx_done
);

  // One bit counter per direction, sized for the widest field.
  localparam int MAX_MP = (META_W > PREFIX_W) ? META_W : PREFIX_W;
  localparam int MAX_W  = (MAX_MP > DATA_W) ? MAX_MP : DATA_W;
  localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int TYPE_BIT = META_W - 2;

  localparam logic [CNT_W-1:0] META_LAST   = CNT_W'(META_W - 1);
  localparam logic [CNT_W-1:0] PREFIX_LAST = CNT_W'(PREFIX_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_META   = 2'd1,
    RX_PREFIX = 2'd2,
    RX_DATA   = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_META   = 3'd2,
    TX_PREFIX = 3'd3,
    TX_DATA   = 3'd4,
    TX_GUARD  = 3'd5
  } tx_state_e;

  // ---------------------------------------------------------------- receive
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic                 rx_type_q, rx_type_d;
  logic [META_W-1:0]    rx_meta_sh_q, rx_meta_sh_d;
  logic [PREFIX_W-1:0]  rx_prefix_sh_q, rx_prefix_sh_d;
  logic [DATA_W-1:0]    rx_data_sh_q, rx_data_sh_d;
  logic [META_W-1:0]    rx_meta_q, rx_meta_d;
  logic [PREFIX_W-1:0]  rx_prefix_q, rx_prefix_d;
  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_abort_q, rx_abort_d;

  // Receive state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_type_q      <= 1'b0;
      rx_meta_sh_q   <= '0;
      rx_prefix_sh_q <= '0;
      rx_data_sh_q   <= '0;
      rx_meta_q      <= '0;
      rx_prefix_q    <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_abort_q     <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_type_q      <= rx_type_d;
      rx_meta_sh_q   <= rx_meta_sh_d;
      rx_prefix_sh_q <= rx_prefix_sh_d;
      rx_data_sh_q   <= rx_data_sh_d;
      rx_meta_q      <= rx_meta_d;
      rx_prefix_q    <= rx_prefix_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_abort_q     <= rx_abort_d;
    end
  end

  // Receive next-state: shift each field in MSB first, publish on the last bit.
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_type_d      = rx_type_q;
    rx_meta_sh_d   = rx_meta_sh_q;
    rx_prefix_sh_d = rx_prefix_sh_q;
    rx_data_sh_d   = rx_data_sh_q;
    rx_meta_d      = rx_meta_q;
    rx_prefix_d    = rx_prefix_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_abort_d     = 1'b0;
    if (rx_state_q != RX_IDLE && cs) begin
      // Chip select lost mid-frame: drop the frame, keep the last good outputs.
      rx_state_d = RX_IDLE;
      rx_abort_d = 1'b1;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!cs && !mosi) begin
            rx_state_d = RX_META;
            rx_cnt_d   = META_LAST;
          end
        end
        RX_META: begin
          rx_meta_sh_d = {rx_meta_sh_q[META_W-2:0], mosi};
          if (rx_cnt_q == '0) begin
            rx_type_d  = rx_meta_sh_d[TYPE_BIT];
            rx_state_d = RX_PREFIX;
            rx_cnt_d   = PREFIX_LAST;
          end else begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
          end
        end
        RX_PREFIX: begin
          rx_prefix_sh_d = {rx_prefix_sh_q[PREFIX_W-2:0], mosi};
          if (rx_cnt_q == '0) begin
            if (rx_type_q) begin
              rx_state_d  = RX_IDLE;
              rx_meta_d   = rx_meta_sh_q;
              rx_prefix_d = rx_prefix_sh_d;
              rx_data_d   = '0;
              rx_valid_d  = 1'b1;
            end else begin
              rx_state_d = RX_DATA;
              rx_cnt_d   = DATA_LAST;
            end
          end else begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
          end
        end
        RX_DATA: begin
          rx_data_sh_d = {rx_data_sh_q[DATA_W-2:0], mosi};
          if (rx_cnt_q == '0) begin
            rx_state_d  = RX_IDLE;
            rx_meta_d   = rx_meta_sh_q;
            rx_prefix_d = rx_prefix_sh_q;
            rx_data_d   = rx_data_sh_d;
            rx_valid_d  = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_abort  = rx_abort_q;
  assign rx_meta   = rx_meta_q;
  assign rx_prefix = rx_prefix_q;
  assign rx_data   = rx_data_q;

  // --------------------------------------------------------------- transmit
  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic                 tx_type_q, tx_type_d;
  logic [META_W-1:0]    tx_meta_sh_q, tx_meta_sh_d;
  logic [PREFIX_W-1:0]  tx_prefix_sh_q, tx_prefix_sh_d;
  logic [DATA_W-1:0]    tx_data_sh_q, tx_data_sh_d;
  logic                 miso_q, miso_d;
  logic                 tx_done_q, tx_done_d;

  // Transmit state and line registers; miso idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q     <= TX_IDLE;
      tx_cnt_q       <= '0;
      tx_type_q      <= 1'b0;
      tx_meta_sh_q   <= '0;
      tx_prefix_sh_q <= '0;
      tx_data_sh_q   <= '0;
      miso_q         <= 1'b1;
      tx_done_q      <= 1'b0;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_type_q      <= tx_type_d;
      tx_meta_sh_q   <= tx_meta_sh_d;
      tx_prefix_sh_q <= tx_prefix_sh_d;
      tx_data_sh_q   <= tx_data_sh_d;
      miso_q         <= miso_d;
      tx_done_q      <= tx_done_d;
    end
  end

  // Transmit next-state: the state names what miso carries after the edge.
  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_cnt_q;
    tx_type_d      = tx_type_q;
    tx_meta_sh_d   = tx_meta_sh_q;
    tx_prefix_sh_d = tx_prefix_sh_q;
    tx_data_sh_d   = tx_data_sh_q;
    miso_d         = miso_q;
    tx_done_d      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        miso_d = 1'b1;
        if (tx_valid) begin
          tx_meta_sh_d   = tx_meta;
          tx_prefix_sh_d = tx_prefix;
          tx_data_sh_d   = tx_data;
          tx_type_d      = tx_meta[TYPE_BIT];
          miso_d         = 1'b0;
          tx_state_d     = TX_START;
        end
      end
      TX_START: begin
        miso_d       = tx_meta_sh_q[META_W-1];
        tx_meta_sh_d = {tx_meta_sh_q[META_W-2:0], 1'b0};
        tx_cnt_d     = META_LAST;
        tx_state_d   = TX_META;
      end
      TX_META: begin
        if (tx_cnt_q == '0) begin
          miso_d         = tx_prefix_sh_q[PREFIX_W-1];
          tx_prefix_sh_d = {tx_prefix_sh_q[PREFIX_W-2:0], 1'b0};
          tx_cnt_d       = PREFIX_LAST;
          tx_state_d     = TX_PREFIX;
        end else begin
          miso_d       = tx_meta_sh_q[META_W-1];
          tx_meta_sh_d = {tx_meta_sh_q[META_W-2:0], 1'b0};
          tx_cnt_d     = tx_cnt_q - CNT_ONE;
        end
      end
      TX_PREFIX: begin
        if (tx_cnt_q == '0) begin
          if (tx_type_q) begin
            miso_d     = 1'b1;
            tx_state_d = TX_GUARD;
          end else begin
            miso_d       = tx_data_sh_q[DATA_W-1];
            tx_data_sh_d = {tx_data_sh_q[DATA_W-2:0], 1'b0};
            tx_cnt_d     = DATA_LAST;
            tx_state_d   = TX_DATA;
          end
        end else begin
          miso_d         = tx_prefix_sh_q[PREFIX_W-1];
          tx_prefix_sh_d = {tx_prefix_sh_q[PREFIX_W-2:0], 1'b0};
          tx_cnt_d       = tx_cnt_q - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          miso_d     = 1'b1;
          tx_state_d = TX_GUARD;
        end else begin
          miso_d       = tx_data_sh_q[DATA_W-1];
          tx_data_sh_d = {tx_data_sh_q[DATA_W-2:0], 1'b0};
          tx_cnt_d     = tx_cnt_q - CNT_ONE;
        end
      end
      TX_GUARD: begin
        miso_d     = 1'b1;
        tx_done_d  = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: begin
        miso_d     = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  assign miso     = miso_q;
  assign tx_done  = tx_done_q;
  assign tx_ready = (tx_state_q == TX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ndn_interface_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_ndn_interface_endpoint
// Purpose  : Self-checking bench for ndn_interface_endpoint; frames are built
//            bit by bit from the field values and compared against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ndn_interface_endpoint;

  logic         clk;
  logic         rst_n;
  logic         mosi_tb;
  logic         loop_en;
  logic         mosi;
  logic         cs;
  logic         miso;
  logic         rx_valid;
  logic         rx_abort;
  logic [7:0]   rx_meta;
  logic [63:0]  rx_prefix;
  logic [255:0] rx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   tx_meta;
  logic [63:0]  tx_prefix;
  logic [255:0] tx_data;
  logic         tx_done;

  int checks = 0;
  int errors = 0;

  // Receive stimulus and observations.
  logic         rx_bits[$];
  int           exp_idx[$];
  logic [7:0]   exp_meta[$];
  logic [63:0]  exp_prefix[$];
  logic [255:0] exp_data[$];
  int           obs_idx[$];
  logic [7:0]   obs_meta[$];
  logic [63:0]  obs_prefix[$];
  logic [255:0] obs_data[$];
  int           ab_idx[$];

  assign mosi = loop_en ? miso : mosi_tb;

  ndn_interface_endpoint #(.META_W(8), .PREFIX_W(64), .DATA_W(256)) dut (
    .clk(clk), .rst(rst_n), .mosi(mosi), .cs(cs), .miso(miso),
    .rx_valid(rx_valid), .rx_abort(rx_abort), .rx_meta(rx_meta),
    .rx_prefix(rx_prefix), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_meta(tx_meta),
    .tx_prefix(tx_prefix), .tx_data(tx_data), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Append one frame to the receive stimulus and predict its completion.
  task automatic append_frame(input logic [7:0] m, input logic [63:0] p, input logic [255:0] d);
    rx_bits.push_back(1'b0);
    for (int b = 7; b >= 0; b--) rx_bits.push_back(m[b]);
    for (int b = 63; b >= 0; b--) rx_bits.push_back(p[b]);
    if (!m[6]) for (int b = 255; b >= 0; b--) rx_bits.push_back(d[b]);
    exp_idx.push_back(rx_bits.size());
    exp_meta.push_back(m);
    exp_prefix.push_back(p);
    exp_data.push_back(m[6] ? 256'd0 : d);
  endtask

  // Drive the queued bits one per cycle, recording every rx pulse by cycle index.
  task automatic drive_rx(input int abort_at);
    obs_idx.delete(); obs_meta.delete(); obs_prefix.delete(); obs_data.delete();
    ab_idx.delete();
    for (int i = 0; i < rx_bits.size() + 4; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        obs_idx.push_back(i);
        obs_meta.push_back(rx_meta);
        obs_prefix.push_back(rx_prefix);
        obs_data.push_back(rx_data);
      end
      if (rx_abort === 1'b1) ab_idx.push_back(i);
      if (i == abort_at) cs = 1'b1;
      mosi_tb = (i < rx_bits.size()) ? rx_bits[i] : 1'b1;
    end
    cs = 1'b0;
    rx_bits.delete();
  endtask

  // Send one frame and check miso bit by bit against the frame built from the fields.
  task automatic run_tx(input logic [7:0] m, input logic [63:0] p, input logic [255:0] d,
                        input bit loop, input int glitch_at);
    logic         exp_q[$];
    int           n;
    int           rxv_at, rxv_cnt, done_at, done_cnt;
    logic [7:0]   cm;
    logic [63:0]  cp;
    logic [255:0] cd;
    rxv_at = -1; rxv_cnt = 0; done_at = -1; done_cnt = 0;
    cm = '0; cp = '0; cd = '0;
    exp_q.push_back(1'b0);
    for (int b = 7; b >= 0; b--) exp_q.push_back(m[b]);
    for (int b = 63; b >= 0; b--) exp_q.push_back(p[b]);
    if (!m[6]) for (int b = 255; b >= 0; b--) exp_q.push_back(d[b]);
    exp_q.push_back(1'b1);
    n = exp_q.size() - 2;
    loop_en = loop;
    @(negedge clk);
    tx_meta = m; tx_prefix = p; tx_data = d; tx_valid = 1'b1;
    for (int j = 1; j <= n + 5; j++) begin
      @(negedge clk);
      if (j == 1) begin
        tx_valid = 1'b0;
        tx_meta = 8'($urandom); tx_prefix = rand64(); tx_data = rand256();
      end
      if (j == glitch_at) tx_valid = 1'b1;
      if (j == glitch_at + 1) tx_valid = 1'b0;
      if (rx_valid === 1'b1) begin
        rxv_cnt++; rxv_at = j; cm = rx_meta; cp = rx_prefix; cd = rx_data;
      end
      if (tx_done === 1'b1) begin done_cnt++; done_at = j; end
      checks++;
      if (j <= n + 2) begin
        if (miso !== exp_q[j-1] || tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL tx_bit cycle %0d miso=%b ready=%b required miso=%b ready=0", j, miso, tx_ready, exp_q[j-1]);
        end
      end else if (miso !== 1'b1 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL tx_idle cycle %0d miso=%b ready=%b required 1/1", j, miso, tx_ready);
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != n + 3) begin
      errors++;
      $display("FAIL tx_done count=%0d at=%0d required count=1 at=%0d", done_cnt, done_at, n + 3);
    end
    checks++;
    if (loop) begin
      if (rxv_cnt != 1 || rxv_at != n + 2 || cm !== m || cp !== p || cd !== (m[6] ? 256'd0 : d)) begin
        errors++;
        $display("FAIL loopback count=%0d at=%0d meta=%h prefix=%h data=%h required 1 at %0d meta=%h prefix=%h data=%h",
                 rxv_cnt, rxv_at, cm, cp, cd, n + 2, m, p, m[6] ? 256'd0 : d);
      end
    end else if (rxv_cnt != 0) begin
      errors++;
      $display("FAIL tx_no_rx rx_valid count=%0d required 0", rxv_cnt);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (rx_valid !== 1'b0 || rx_abort !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses valid=%b abort=%b done=%b required 0", rx_valid, rx_abort, tx_done);
    end
    checks++;
    if (rx_meta !== 8'd0 || rx_prefix !== 64'd0 || rx_data !== 256'd0) begin
      errors++;
      $display("FAIL reset_rx_fields meta=%h prefix=%h data=%h required 0", rx_meta, rx_prefix, rx_data);
    end
    checks++;
    if (miso !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx miso=%b ready=%b required 1/1", miso, tx_ready);
    end
  endtask

  task automatic test_rx_interest();
    logic [255:0] junk;
    junk = rand256();
    append_frame(8'h48, 64'hDEADBEEF_01234567, junk);
    drive_rx(-1);
    checks++;
    if (obs_idx.size() != 1 || ab_idx.size() != 0) begin
      errors++;
      $display("FAIL rx_interest_count valid=%0d abort=%0d required 1/0", obs_idx.size(), ab_idx.size());
    end else begin
      checks++;
      if (obs_idx[0] != 73) begin
        errors++;
        $display("FAIL rx_interest_latency got %0d required 73", obs_idx[0]);
      end
      checks++;
      if (obs_meta[0] !== 8'h48 || obs_prefix[0] !== 64'hDEADBEEF_01234567 || obs_data[0] !== 256'd0) begin
        errors++;
        $display("FAIL rx_interest_fields meta=%h prefix=%h data=%h", obs_meta[0], obs_prefix[0], obs_data[0]);
      end
    end
    exp_idx.delete(); exp_meta.delete(); exp_prefix.delete(); exp_data.delete();
  endtask

  task automatic test_rx_data();
    append_frame(8'h08, 64'h1, {32{8'hA5}});
    drive_rx(-1);
    checks++;
    if (obs_idx.size() != 1) begin
      errors++;
      $display("FAIL rx_data_count got %0d required 1", obs_idx.size());
    end else begin
      checks++;
      if (obs_idx[0] != 329) begin
        errors++;
        $display("FAIL rx_data_latency got %0d required 329", obs_idx[0]);
      end
      checks++;
      if (obs_meta[0] !== 8'h08 || obs_prefix[0] !== 64'h1 || obs_data[0] !== {32{8'hA5}}) begin
        errors++;
        $display("FAIL rx_data_fields meta=%h prefix=%h data=%h", obs_meta[0], obs_prefix[0], obs_data[0]);
      end
    end
    exp_idx.delete(); exp_meta.delete(); exp_prefix.delete(); exp_data.delete();
  endtask

  task automatic test_abort();
    logic [7:0] m;
    logic [63:0] p;
    logic [255:0] d;
    m = 8'($urandom); m[6] = 1'b1;
    append_frame(m, rand64(), rand256());
    drive_rx(28);                       // cs rises while sampling prefix bit 20
    checks++;
    if (ab_idx.size() != 1 || obs_idx.size() != 0) begin
      errors++;
      $display("FAIL abort_pulses abort=%0d valid=%0d required 1/0", ab_idx.size(), obs_idx.size());
    end else begin
      checks++;
      if (ab_idx[0] != 29) begin
        errors++;
        $display("FAIL abort_timing got %0d required 29", ab_idx[0]);
      end
    end
    checks++;
    if (rx_meta !== 8'h08 || rx_prefix !== 64'h1 || rx_data !== {32{8'hA5}}) begin
      errors++;
      $display("FAIL abort_hold meta=%h prefix=%h data=%h required previous frame", rx_meta, rx_prefix, rx_data);
    end
    exp_idx.delete(); exp_meta.delete(); exp_prefix.delete(); exp_data.delete();
    m = 8'($urandom); m[6] = 1'b0;
    p = rand64(); d = rand256();
    append_frame(m, p, d);
    drive_rx(-1);
    checks++;
    if (obs_idx.size() != 1 || obs_meta[0] !== m || obs_prefix[0] !== p || obs_data[0] !== d) begin
      errors++;
      $display("FAIL abort_recover count=%0d required 1 meta=%h prefix=%h", obs_idx.size(), m, p);
    end
    exp_idx.delete(); exp_meta.delete(); exp_prefix.delete(); exp_data.delete();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 5; f++) append_frame(8'($urandom), rand64(), rand256());
    drive_rx(-1);
    checks++;
    if (obs_idx.size() != exp_idx.size() || ab_idx.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d required %0d aborts=%0d", obs_idx.size(), exp_idx.size(), ab_idx.size());
    end else begin
      for (int f = 0; f < exp_idx.size(); f++) begin
        checks++;
        if (obs_idx[f] != exp_idx[f] || obs_meta[f] !== exp_meta[f] ||
            obs_prefix[f] !== exp_prefix[f] || obs_data[f] !== exp_data[f]) begin
          errors++;
          $display("FAIL b2b_frame%0d at=%0d meta=%h prefix=%h required at=%0d meta=%h prefix=%h",
                   f, obs_idx[f], obs_meta[f], obs_prefix[f], exp_idx[f], exp_meta[f], exp_prefix[f]);
        end
      end
    end
    exp_idx.delete(); exp_meta.delete(); exp_prefix.delete(); exp_data.delete();
  endtask

  task automatic test_tx_interest();
    run_tx(8'h7F, 64'hFFFF0000FFFF0000, rand256(), 1'b0, 30);
  endtask

  task automatic test_loopback();
    logic [7:0] m;
    m = 8'($urandom); m[6] = 1'b0;
    run_tx(m, rand64(), rand256(), 1'b1, -1);
    m = 8'($urandom); m[6] = 1'b1;
    run_tx(m, rand64(), rand256(), 1'b1, -1);
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    logic [7:0] m;
    bad = 0;
    loop_en = 1'b1;
    m = 8'($urandom); m[6] = 1'b0;
    @(negedge clk);
    tx_meta = m; tx_prefix = rand64(); tx_data = rand256(); tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (150) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (miso !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_tx_immediate miso=%b ready=%b required 1/1", miso, tx_ready);
    end
    checks++;
    if (rx_meta !== 8'd0 || rx_prefix !== 64'd0 || rx_data !== 256'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rx_immediate meta=%h prefix=%h valid=%b required 0", rx_meta, rx_prefix, rx_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (miso !== 1'b1 || rx_valid !== 1'b0 || tx_done !== 1'b0 || rx_abort !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_quiet activity cycles=%0d required 0", bad);
    end
    loop_en = 1'b0;
    m = 8'($urandom); m[6] = 1'b0;
    run_tx(m, rand64(), rand256(), 1'b1, -1);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; mosi_tb = 1'b1; loop_en = 1'b0;
    tx_valid = 1'b0; tx_meta = '0; tx_prefix = '0; tx_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_rx_interest();
    test_rx_data();
    test_abort();
    test_back_to_back();
    test_tx_interest();
    test_loopback();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
